mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 SHALL have parameter OP_W, default 1024: operand width in bits (multiple of WORD_W, max 2048).
REQ-002 SHALL have parameter WORD_W, default 32: load word width; NW = OP_W/WORD_W, PW = clog2(NW), CW = clog2(OP_W)+1.
REQ-003 SHALL have port clk  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_valid  in  1  single-cycle operand-word write request (touchscreen input_valid).
REQ-006 SHALL have port wr_sel  in  1  target operand: 0 = In1, 1 = In2.
REQ-007 SHALL have port wr_data  in  WORD_W  operand word.
REQ-008 SHALL have port start  in  1  single-cycle multiply request.
REQ-009 SHALL have port abort  in  1  single-cycle cancel request.
REQ-010 SHALL have port mul_rem_zero  in  1  datapath flag: remaining multiplier bits all zero.
REQ-011 SHALL have port op_we  out  1  operand word write strobe to datapath.
REQ-012 SHALL have port op_sel  out  1  operand select for op_we.
REQ-013 SHALL have port op_widx  out  PW  word index for op_we (word 0 = bits [WORD_W-1:0]).
REQ-014 SHALL have port op_wdata  out  WORD_W  word data for op_we.
REQ-015 SHALL have port mul_clr  out  1  clears product/shift registers in datapath.
REQ-016 SHALL have port mul_step  out  1  advances serial multiplier one bit.
REQ-017 SHALL have ports busy  out  1, done  out  1, wr_drop  out  1, step_cnt  out  CW, ptr0  out  PW, ptr1  out  PW (status).

Function
REQ-018 SHALL implement states IDLE, CLEAR, RUN, DONE; busy = 1 in CLEAR and RUN only.
REQ-019 In IDLE/DONE, accepted wr_valid SHALL produce op_we = 1 next cycle with op_sel = wr_sel, op_widx = ptr[wr_sel], op_wdata = wr_data; ptr[wr_sel] then increments, NW-1 wraps to 0.
REQ-020 An accepted write in DONE SHALL clear done and move to IDLE.
REQ-021 wr_valid in CLEAR/RUN SHALL be discarded: no op_we, pointers unchanged, wr_drop = 1 next cycle for one cycle.
REQ-022 start in IDLE/DONE at cycle t SHALL give mul_clr = 1 at t+1 (CLEAR), mul_step = 1 at t+2..t+1+OP_W (RUN), done = 1 from t+2+OP_W (DONE).
REQ-023 start and wr_valid in the same IDLE/DONE cycle: start SHALL win; write discarded with wr_drop.
REQ-024 start while busy SHALL be ignored.
REQ-025 step_cnt SHALL clear at CLEAR, increment per mul_step, and hold final value in DONE.
REQ-026 done SHALL remain 1 until next accepted start, accepted write, or reset.
REQ-027 abort in CLEAR/RUN SHALL return to IDLE next cycle, mul_step = 0 from that cycle, done = 0, step_cnt held; abort in IDLE/DONE ignored; abort and start same cycle: abort wins.
REQ-028 op_we, mul_clr, mul_step SHALL never be 1 in the same cycle.

Reset
REQ-029 On resetn = 0: state IDLE, ptr0 = ptr1 = 0, step_cnt = 0, all strobes and busy/done/wr_drop = 0, op_widx = 0, op_wdata = 0, op_sel = 0.
REQ-030 Reset mid-RUN SHALL terminate immediately with no further mul_step.

Configuration
REQ-031 Macro MUL_SEQ_EARLY_EXIT_EN defined: in RUN, mul_rem_zero = 1 with step_cnt >= 1 SHALL end RUN at that cycle (no mul_step), DONE next cycle; step_cnt holds actual steps.
REQ-032 Macro undefined: mul_rem_zero ignored; RUN always exactly OP_W steps.

Verification
REQ-033 Reset, 3 writes wr_sel=0 data 0x1,0x2,0x3 -> op_widx 0,1,2 on op_sel 0; ptr0 = 3, ptr1 = 0.
REQ-034 NW+1 writes wr_sel=1 -> last op_widx = 0 (wrap), ptr1 = 1.
REQ-035 start at cycle 10, OP_W=1024, macro off -> mul_clr at 11, mul_step 12..1035, done at 1036, step_cnt = 1024.
REQ-036 wr_valid and start during RUN at step 100 -> wr_drop pulse, no op_we, start ignored, done still at original cycle.
REQ-037 abort at step 500 -> IDLE next cycle, busy = 0, done = 0, step_cnt = 500.
REQ-038 Macro on, mul_rem_zero asserted after 8 steps -> exactly 8 mul_step pulses, done next cycle, step_cnt = 8.

Source files
------------

// File: rtl/mul_seq_ctrl.sv
// Sequencer for a bit-serial OP_W x OP_W multiplier: loads operand words, clears, steps, reports done.
// Optional MUL_SEQ_EARLY_EXIT_EN: finish RUN early once the remaining multiplier bits are all zero.
module mul_seq_ctrl #(
    parameter  int OP_W   = 1024,
    parameter  int WORD_W = 32,
    localparam int NW     = OP_W / WORD_W,
    localparam int PW     = (NW > 1) ? $clog2(NW) : 1,
    localparam int CW     = $clog2(OP_W) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_valid,
    input  logic              wr_sel,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    input  logic              abort,
    input  logic              mul_rem_zero,
    output logic              op_we,
    output logic              op_sel,
    output logic [PW-1:0]     op_widx,
    output logic [WORD_W-1:0] op_wdata,
    output logic              mul_clr,
    output logic              mul_step,
    output logic              busy,
    output logic              done,
    output logic              wr_drop,
    output logic [CW-1:0]     step_cnt,
    output logic [PW-1:0]     ptr0,
    output logic [PW-1:0]     ptr1
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t state, state_nxt;
    logic   idle_like, start_acc, wr_acc, early_exit, run_step, step_last;

    assign idle_like = (state == IDLE) || (state == DONE);
    // A simultaneous abort cancels a start; a start always beats a write.
    assign start_acc = idle_like && start && !abort;
    assign wr_acc    = idle_like && wr_valid && !start_acc;
    assign step_last = (step_cnt == CW'(OP_W - 1));

`ifdef MUL_SEQ_EARLY_EXIT_EN
    assign early_exit = (state == RUN) && mul_rem_zero && (step_cnt != '0);
`else
    logic unused_rem_zero;
    assign unused_rem_zero = mul_rem_zero;
    assign early_exit      = 1'b0;
`endif

    assign run_step = (state == RUN) && !abort && !early_exit;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_acc) state_nxt = CLEAR;
            CLEAR: state_nxt = abort ? IDLE : RUN;
            RUN: begin
                if (abort)                       state_nxt = IDLE;
                else if (early_exit || step_last) state_nxt = DONE;
            end
            DONE: begin
                if (start_acc)   state_nxt = CLEAR;
                else if (wr_acc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by resetn so an in-flight RUN stops stepping the moment reset asserts.
    always_comb begin
        mul_clr  = resetn && (state == CLEAR);
        mul_step = resetn && run_step;
        busy     = resetn && ((state == CLEAR) || (state == RUN));
        done     = resetn && (state == DONE);
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NW - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            step_cnt <= '0;
            ptr0     <= '0;
            ptr1     <= '0;
            op_we    <= 1'b0;
            op_sel   <= 1'b0;
            op_widx  <= '0;
            op_wdata <= '0;
            wr_drop  <= 1'b0;
        end else begin
            if (start_acc)     step_cnt <= '0;
            else if (run_step) step_cnt <= step_cnt + 1'b1;

            op_we   <= wr_acc;
            wr_drop <= wr_valid && !wr_acc;
            if (wr_acc) begin
                op_sel   <= wr_sel;
                op_widx  <= wr_sel ? ptr1 : ptr0;
                op_wdata <= wr_data;
                if (wr_sel) ptr1 <= ptr_inc(ptr1);
                else        ptr0 <= ptr_inc(ptr0);
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: operand writes, full run timing, drop/abort/reset cases.
module tb_mul_seq_ctrl;
    localparam int OP_W   = 1024;
    localparam int WORD_W = 32;
    localparam int NW     = OP_W / WORD_W;
    localparam int PW     = $clog2(NW);
    localparam int CW     = $clog2(OP_W) + 1;

    logic              clk = 1'b0;
    logic              resetn, wr_valid, wr_sel, start, abort, mul_rem_zero;
    logic [WORD_W-1:0] wr_data;
    logic              op_we, op_sel, mul_clr, mul_step, busy, done, wr_drop;
    logic [PW-1:0]     op_widx, ptr0, ptr1;
    logic [WORD_W-1:0] op_wdata;
    logic [CW-1:0]     step_cnt;

    typedef struct packed {
        logic              sel;
        logic [PW-1:0]     idx;
        logic [WORD_W-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           got;
    logic [PW-1:0] mptr[2];
    int n_chk = 0, n_err = 0, cyc = 0, t0 = 0;
    int clr_cyc = -1, first_step = -1, last_step = -1, nsteps = 0, done_cyc = -1, viol = 0;
    logic done_q = 1'b0;

    mul_seq_ctrl #(.OP_W(OP_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data),
        .start(start), .abort(abort), .mul_rem_zero(mul_rem_zero),
        .op_we(op_we), .op_sel(op_sel), .op_widx(op_widx), .op_wdata(op_wdata),
        .mul_clr(mul_clr), .mul_step(mul_step), .busy(busy), .done(done), .wr_drop(wr_drop),
        .step_cnt(step_cnt), .ptr0(ptr0), .ptr1(ptr1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe and records strobe timing.
    always @(negedge clk) begin
        if (op_we) begin
            if (exp_q.size() == 0) chk("op_we_unexpected", 1, 0);
            else begin
                got = exp_q.pop_front();
                chk("op_sel", op_sel, got.sel);
                chk("op_widx", op_widx, got.idx);
                chk("op_wdata", op_wdata, got.data);
            end
        end
        if (int'(op_we) + int'(mul_clr) + int'(mul_step) > 1) viol++;
        if (mul_clr) begin
            clr_cyc = cyc; nsteps = 0; first_step = -1;
        end
        if (mul_step) begin
            nsteps++;
            if (first_step < 0) first_step = cyc;
            last_step = cyc;
        end
        if (done && !done_q) done_cyc = cyc;
        done_q = done;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic sel, input logic [WORD_W-1:0] data);
        wr_t e;
        wr_valid = 1'b1; wr_sel = sel; wr_data = data;
        e.sel = sel; e.idx = mptr[sel]; e.data = data;
        exp_q.push_back(e);
        mptr[sel] = (mptr[sel] == PW'(NW - 1)) ? '0 : mptr[sel] + 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic go();
        start = 1'b1; t0 = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_cnt(input int v, input int budget);
        int k = 0;
        while (step_cnt != CW'(v) && k < budget) begin step(); k++; end
        if (step_cnt != CW'(v)) chk("timeout_step_cnt", step_cnt, v);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin step(); k++; end
        if (!done) chk("timeout_done", 0, 1);
    endtask

    initial begin
        resetn = 1'b0; wr_valid = 1'b0; wr_sel = 1'b0; wr_data = '0;
        start = 1'b0; abort = 1'b0; mul_rem_zero = 1'b0;
        mptr[0] = '0; mptr[1] = '0;
        repeat (3) step();
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_step_cnt", step_cnt, 0);
        chk("rst_ptr0", ptr0, 0);      chk("rst_ptr1", ptr1, 0);
        chk("rst_op_we", op_we, 0);    chk("rst_op_sel", op_sel, 0);
        chk("rst_op_widx", op_widx, 0); chk("rst_op_wdata", op_wdata, 0);
        chk("rst_wr_drop", wr_drop, 0);
        chk("rst_mul_clr", mul_clr, 0); chk("rst_mul_step", mul_step, 0);
        resetn = 1'b1;
        step();

        wr(0, 32'h1); wr(0, 32'h2); wr(0, 32'h3);
        step();
        chk("ptr0_after3", ptr0, 3);
        chk("ptr1_after3", ptr1, 0);

        for (int i = 0; i <= NW; i++) wr(1, $urandom);
        step();
        chk("ptr1_wrap", ptr1, mptr[1]);
        chk("ptr0_hold", ptr0, mptr[0]);

        // Full run; mul_rem_zero held high must not shorten it in the default build.
`ifndef MUL_SEQ_EARLY_EXIT_EN
        mul_rem_zero = 1'b1;
`endif
        go();
        wait_cnt(100, 200);
        wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 32'hDEAD; start = 1'b1;
        step();
        wr_valid = 1'b0; start = 1'b0;
        chk("run_wr_drop", wr_drop, 1);
        chk("run_no_op_we", op_we, 0);
        chk("run_busy", busy, 1);
        step();
        chk("run_wr_drop_pulse", wr_drop, 0);
        chk("run_ptr0_hold", ptr0, mptr[0]);
        wait_done(1200);
        step();
        mul_rem_zero = 1'b0;
        chk("clr_cycle", clr_cyc, t0 + 1);
        chk("first_step_cycle", first_step, t0 + 2);
        chk("last_step_cycle", last_step, t0 + 1 + OP_W);
        chk("done_cycle", done_cyc, t0 + 2 + OP_W);
        chk("step_pulses", nsteps, OP_W);
        chk("final_step_cnt", step_cnt, OP_W);
        chk("done_busy", busy, 0);

        repeat (5) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("done_sticky", done, 1);
        chk("done_cnt_hold", step_cnt, OP_W);
        wr(0, 32'h55);
        chk("wr_clears_done", done, 0);
        chk("wr_idle_busy", busy, 0);

        go();
        chk("clear_mul_clr", mul_clr, 1);
        chk("clear_cnt", step_cnt, 0);
        wait_cnt(500, 600);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_mul_step", mul_step, 0);
        chk("abort_cnt", step_cnt, 500);
        step();
        chk("abort_pulses", nsteps, 500);

        wr_valid = 1'b1; wr_sel = 1'b1; wr_data = 32'hBEEF; start = 1'b1;
        step();
        wr_valid = 1'b0; start = 1'b0;
        chk("start_wins_drop", wr_drop, 1);
        chk("start_wins_no_we", op_we, 0);
        chk("start_wins_clr", mul_clr, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("clear_abort_busy", busy, 0);
        chk("start_wins_ptr1", ptr1, mptr[1]);

`ifdef MUL_SEQ_EARLY_EXIT_EN
        go();
        wait_cnt(8, 20);
        mul_rem_zero = 1'b1;
        step();
        mul_rem_zero = 1'b0;
        chk("early_done", done, 1);
        chk("early_cnt", step_cnt, 8);
        step();
        chk("early_pulses", nsteps, 8);
`endif

        go();
        wait_cnt(20, 40);
        resetn = 1'b0;
        #1;
        chk("rst_mid_no_step", mul_step, 0);
        step();
        mptr[0] = '0; mptr[1] = '0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_cnt", step_cnt, 0);
        chk("rst_mid_ptr0", ptr0, 0);
        resetn = 1'b1;
        repeat (2) step();
        chk("rst_mid_pulses", nsteps, 20);
        chk("rst_mid_idle_step", mul_step, 0);

        chk("strobe_mutex", viol, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
